// File: rtl/ram_1port_initiator_pkg.sv
// Shared definitions for the single-port RAM command front end:
// default geometry, depth derivation and FSM state encodings.
package ram_1port_initiator_pkg;

  localparam int unsigned AW_DEF  = 7;
  localparam int unsigned DW_DEF  = 4;
  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  // Encodings kept as plain constants so older blocks can compare against them
  localparam state_t ST_INIT  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_READ  = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ram_1port_initiator.sv
// Command-side front end for a single-port RAM: clears the array after reset,
// then serves one read or write command at a time over valid/ready.
module ram_1port_initiator
  import ram_1port_initiator_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          init_done,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned   DEPTH     = depth_of(AW);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] init_cnt, init_cnt_nxt;
  logic          ram_we_nxt;
  logic [AW-1:0] ram_addr_nxt;
  logic [DW-1:0] ram_wdata_nxt;
  logic          rsp_valid_nxt;
  logic [DW-1:0] rsp_data_nxt;
  logic          init_done_nxt;

  assign cmd_ready = (state == ST_IDLE);

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wdata <= ram_wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      init_done <= init_done_nxt;
    end
  end

  // Next-state and next-output decode; write enable drops unless re-asserted
  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    ram_we_nxt    = 1'b0;
    ram_addr_nxt  = ram_addr;
    ram_wdata_nxt = ram_wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    init_done_nxt = init_done;

    case (state)
      ST_INIT: begin
        // The last clear write is on the port this cycle, so it lands now
        if (ram_we && (ram_addr == LAST_ADDR)) begin
          state_nxt     = ST_IDLE;
          init_done_nxt = 1'b1;
        end else begin
          ram_we_nxt    = 1'b1;
          ram_addr_nxt  = init_cnt;
          ram_wdata_nxt = '0;
          if (init_cnt != LAST_ADDR) begin
            init_cnt_nxt = init_cnt + AW'(1);
          end
        end
      end

      ST_IDLE: begin
        if (cmd_valid) begin
          ram_addr_nxt = cmd_addr;
          if (cmd_write) begin
            ram_we_nxt    = 1'b1;
            ram_wdata_nxt = cmd_wdata;
            state_nxt     = ST_WRITE;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        state_nxt = ST_IDLE;
      end

      ST_READ: begin
        rsp_valid_nxt = 1'b1;
        rsp_data_nxt  = ram_rdata;
        state_nxt     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

endmodule
